// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low columns, images the rows once per
// full scan, and debounces single-key presses/releases into key_valid/key_code/key_held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // state   | meaning
  // IDLE    | no key reported, waiting for a single-key scan
  // CONFIRM | same single key seen on cnt consecutive scans
  // HELD    | key reported, waiting for an empty scan
  // RELEASE | cnt consecutive empty scans seen since HELD
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [3:0]      row_meta, row_sync;
  logic [DW-1:0]   dwell;
  logic [1:0]      col_idx;
  logic            last_dwell, eval;
  logic [3:0][3:0] image, image_next;
  logic [1:0]      nbits;
  logic [3:0]      hit_idx;
  logic            scan_none, scan_single;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [3:0]      cand, cand_n, code_n;
  logic            valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign last_dwell = (dwell == DWELL_LAST);
  assign eval       = last_dwell && (col_idx == 2'd3);
  assign col        = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (last_dwell) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // The current column is merged in combinationally so evaluation on column 3
  // sees a complete image in the same cycle it is latched.
  always_comb begin
    image_next = image;
    for (int r = 0; r < 4; r++) begin
      image_next[r][col_idx] = ~row_sync[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image <= '0;
    end else if (last_dwell) begin
      image <= image_next;
    end
  end

  // nbits saturates at 2, which is all the classifier needs to tell MULTI apart.
  always_comb begin
    nbits   = '0;
    hit_idx = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (image_next[r][c]) begin
          hit_idx = {2'(r), 2'(c)};
          if (nbits != 2'd2) nbits = nbits + 2'd1;
        end
      end
    end
  end

  assign scan_none   = (nbits == 2'd0);
  assign scan_single = (nbits == 2'd1);
  assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
    if (eval) begin
      unique case (state)
        IDLE: begin
          if (scan_single) begin
            cand_n  = hit_idx;
            cnt_n   = CNT_ONE;
            state_n = CONFIRM;
          end
        end
        CONFIRM: begin
          if (scan_single && (hit_idx == cand)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              code_n  = cand;
              valid_n = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (scan_none) begin
            cnt_n   = CNT_ONE;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (scan_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              cnt_n   = '0;
              state_n = IDLE;
            end
          end else begin
            cnt_n   = '0;
            state_n = HELD;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
    end
  end

  assign key_held = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives the rows, and a
// scoreboard of expected (code, time) pulses is checked by a key_valid monitor.
module tb_keypad_scanner;

  localparam int          SCAN = 16;
  localparam logic [63:0] PER  = 64'd10;

  typedef struct {
    logic [3:0]  code;
    logic [63:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed;
  logic        prev_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  exp_t        sbq[$];
  exp_t        got;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A press applied now must report three full scans later, on a negedge.
  task automatic expect_press(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.t    = ($time / PER) * PER + 3 * SCAN * PER;
    sbq.push_back(e);
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulses++;
      chk("valid_with_held", key_held, 1);
      chk("valid_one_cycle", prev_valid, 0);
      chk("valid_in_reset", rst, 0);
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed=code %0h expected=no pulse", key_code);
      end
      if (sbq.size() > 0) begin
        got = sbq.pop_front();
        chk("pulse_code", key_code, got.code);
        chk("pulse_time", $time, got.t);
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    logic [3:0] ec;
    rst = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ec = ~(4'b0001 << (i / 4));
      chk("col_seq", col, ec);
      @(negedge clk);
    end
    for (int s = 0; s < 20; s++) begin
      scans(1);
      chk("idle_held", key_held, 0);
      chk("idle_code", key_code, 0);
    end
    #1 chk("idle_pulses", pulses, 0);

    // single press of (2,1), then release
    pressed = 16'h0200;
    expect_press(4'h9);
    for (int s = 1; s <= 10; s++) begin
      scans(1);
      chk("b_held_press", key_held, (s >= 3));
    end
    pressed = '0;
    for (int s = 1; s <= 10; s++) begin
      scans(1);
      chk("b_held_release", key_held, (s < 3));
    end
    #1 chk("b_pulses", pulses, 1);
    chk("b_code", key_code, 4'h9);

    // bounce on key 6
    pressed = 16'h0040;
    scans(2);
    pressed = '0;
    scans(1);
    #1 chk("c_no_early", pulses, 1);
    chk("c_held_early", key_held, 0);
    pressed = 16'h0040;
    expect_press(4'h6);
    scans(2);
    chk("c_held_2", key_held, 0);
    scans(1);
    chk("c_held_3", key_held, 1);
    scans(2);
    pressed = '0;
    scans(4);
    chk("c_held_end", key_held, 0);
    #1 chk("c_pulses", pulses, 2);
    chk("c_code", key_code, 4'h6);

    // two keys together never report
    pressed = 16'h8001;
    for (int s = 0; s < 10; s++) begin
      scans(1);
      chk("d_held", key_held, 0);
    end
    pressed = '0;
    scans(1);
    #1 chk("d_pulses", pulses, 2);

    // key 5 held, A added, 5 released, then all released
    pressed = 16'h0020;
    expect_press(4'h5);
    scans(3);
    chk("e_held_accept", key_held, 1);
    scans(1);
    pressed = 16'h0420;
    for (int s = 0; s < 3; s++) begin
      scans(1);
      chk("e_held_both", key_held, 1);
    end
    pressed = 16'h0400;
    for (int s = 0; s < 3; s++) begin
      scans(1);
      chk("e_held_a_only", key_held, 1);
    end
    pressed = '0;
    for (int s = 1; s <= 4; s++) begin
      scans(1);
      chk("e_held_release", key_held, (s < 3));
    end
    #1 chk("e_pulses", pulses, 3);
    chk("e_code", key_code, 4'h5);

    // reset in the middle of confirming key 3
    pressed = 16'h0008;
    scans(2);
    rst = 1'b1;
    #1;
    chk("f_rst_col", col, 4'b1110);
    chk("f_rst_code", key_code, 0);
    chk("f_rst_valid", key_valid, 0);
    chk("f_rst_held", key_held, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_press(4'h3);
    scans(2);
    chk("f_held_2", key_held, 0);
    scans(1);
    chk("f_held_3", key_held, 1);
    pressed = '0;
    scans(4);
    chk("f_held_end", key_held, 0);
    #1 chk("f_pulses", pulses, 4);
    chk("f_code", key_code, 4'h3);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the 4x4 keypad. It drives the column lines active-low one at a time and samples the row lines. Scan results are debounced, and each confirmed key press is delivered as a one-cycle `key_valid` pulse with a 4-bit `key_code`. Downstream control state machines consume `key_valid`/`key_code`/`key_held` and never touch the matrix pins directly.

## Interface
- `SCAN_DIV`, 50000: clock cycles each column is driven; must be >= 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans needed to accept a press or a release; must be >= 2.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `row` in 4: keypad rows, active-low. Pulled up externally. Asynchronous to `clk`.
- `col` out 4: keypad columns, active-low, one-hot-zero.
- `key_code` out 4: {row_index[1:0], col_index[1:0]} of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_held` out 1: high from acceptance until the release is confirmed.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column driver:
  - Dwell counter counts 0..`SCAN_DIV`-1.
  - On wrap, `col` rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110. Column index c = position of the zero bit.
- Sampling:
  - On the last dwell cycle of each column, latch the synchronized row into a 16-bit scan image: bit (r*4+c) = ~row_sync[r].
- Scan result, evaluated on the last dwell cycle of column 3, one per full scan:
  - NONE: image == 0.
  - SINGLE(k): exactly one bit set; k = its index.
  - MULTI: two or more bits set.
- State machine (state and count update only at scan evaluation):
  - IDLE: SINGLE(k) -> cand=k, cnt=1, go to CONFIRM. NONE or MULTI -> stay.
  - CONFIRM: SINGLE(cand) -> cnt+1. When cnt+1 == `DEBOUNCE_SCANS`: `key_code`=cand, pulse `key_valid`, go to HELD. Any other result -> go to IDLE, cnt=0.
  - HELD: NONE -> cnt=1, go to RELEASE. SINGLE (any key) or MULTI -> stay. No new report is made until a release is confirmed.
  - RELEASE: NONE -> cnt+1. When cnt+1 == `DEBOUNCE_SCANS` -> go to IDLE. Not NONE -> go to HELD.
- `key_held` = 1 in HELD and RELEASE, 0 otherwise.
- `key_code` holds its value until the next accepted press.
- Ghosting or multi-key input never produces a report.
- Counters:
  - Dwell counter width = clog2(`SCAN_DIV`).
  - Debounce counter width = clog2(`DEBOUNCE_SCANS`+1). It saturates and never wraps.

## Timing
- Reset values (applied asynchronously, immediately): `col`=1110, dwell=0, scan image=0, state=IDLE, cnt=0, `key_code`=0, `key_valid`=0, `key_held`=0, synchronizer flops=1111.
- Reset asserted mid-operation aborts any pending confirm. No `key_valid` pulse may appear while `rst`=1 or on the first cycle after release.
- Scan period is 4*`SCAN_DIV` cycles.
- `key_valid` and `key_held` rise together on the cycle after the evaluating edge. `key_valid` lasts exactly one cycle.
- Press latency: after a key becomes stable, `key_valid` fires within (`DEBOUNCE_SCANS`+1) scan periods + 3 cycles.
- Release latency: `key_held` falls within the same bound.
- Sample point: `row` must be stable at least 3 cycles before the last dwell cycle, which covers synchronizer delay plus one settle cycle.

## Test plan
Bench settings: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3. Key model: row[r]=0 while col[c]=0 and key (r,c) is pressed.

- Reset release: `col`=1110 for 4 cycles, then 1101, 1011, 0111, repeating. `key_valid`=`key_held`=0 and `key_code`=0 with no keys pressed over 20 scans.
- Press (r=2,c=1) for 10 scans, then release for 10 scans: exactly one `key_valid` pulse with `key_code`=4'h9, and `key_held`=1 from that pulse. `key_held` falls after 3 empty scans. No further pulse.
- Bounce: key 4'h6 pressed 2 scans, released 1 scan, then pressed 5 scans: no pulse during the first 3 scans. Exactly one pulse, `key_code`=4'h6, at the 3rd consecutive pressed scan.
- Keys (0,0) and (3,3) pressed together for 10 scans: zero pulses, `key_held`=0 throughout.
- Key 4'h5 accepted, then 4'hA added while 5 is still held, then 5 released while A stays pressed: no second pulse and `key_held` stays 1. Release all keys: `key_held` falls after 3 empty scans.
- `rst` pulsed mid-CONFIRM, after 2 pressed scans of key 4'h3: outputs return to reset values immediately. With the key still pressed after reset, a pulse appears only after 3 fresh full scans.
